// File: rtl/ssd_scan_mux_if.sv
// Bundle between the BCD source and the seven-segment scan multiplexer.
interface ssd_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   bcd_in;
    logic                      A;
    logic                      B;
    logic                      C;
    logic                      D;
    logic [NUM_DIGITS-1:0]     dig_en;
    logic                      frame_done;

    modport master (
        output load, bcd_in,
        input  A, B, C, D, dig_en, frame_done
    );

    modport slave (
        input  load, bcd_in,
        output A, B, C, D, dig_en, frame_done
    );
endinterface

// File: rtl/ssd_scan_mux.sv
// Time-multiplexed BCD digit scanner with blank gaps and frame-boundary commit.
// Optional LEADING_ZERO_BLANK_EN: leading zero digits (above digit 0) stay dark.
module ssd_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 1000,
    parameter int BLANK      = 16
) (
    input logic           clk,
    input logic           rst,
    ssd_scan_mux_if.slave bus
);
    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int W    = 4 * NUM_DIGITS;

    typedef enum logic {
        S_BLANK,
        S_SHOW
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [W-1:0]          disp_q, disp_d;
    logic [W-1:0]          shad_q, shad_d;
    logic                  pend_q, pend_d;
    logic [3:0]            nib_q, nib_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic                  fd_q, fd_d;
    logic                  last;
    logic                  wrap;
    logic                  lit;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] hi_zero;

    // hi_zero[k]: digits k..NUM_DIGITS-1 of the shown value are all zero
    always_comb begin
        hi_zero = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            hi_zero[k] = ((disp_q >> (4 * k)) == '0);
        end
    end

    assign lit = (idx_q == '0) || !hi_zero[idx_q];
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        disp_d  = disp_q;
        shad_d  = shad_q;
        pend_d  = pend_q;
        wrap    = 1'b0;

        if (state_q == S_BLANK) last = (cnt_q == CW'(BLANK - 1));
        else                    last = (cnt_q == CW'(DWELL - 1));

        cnt_d = last ? '0 : cnt_q + 1'b1;

        if (last) begin
            if (state_q == S_BLANK) begin
                state_d = S_SHOW;
            end else begin
                state_d = S_BLANK;
                if (idx_q == IW'(NUM_DIGITS - 1)) begin
                    idx_d = '0;
                    wrap  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end

        if (bus.load) begin
            shad_d = bus.bcd_in;
            pend_d = 1'b1;
        end

        // A load coinciding with the wrap bypasses the shadow register
        if (wrap) begin
            if (bus.load) begin
                disp_d = bus.bcd_in;
                pend_d = 1'b0;
            end else if (pend_q) begin
                disp_d = shad_q;
                pend_d = 1'b0;
            end
        end

        nib_d = disp_q[{idx_q, 2'b00} +: 4];
        en_d  = '1;
        if (state_q == S_SHOW && lit) en_d[idx_q] = 1'b0;
        fd_d  = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BLANK;
            idx_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            shad_q  <= '0;
            pend_q  <= 1'b0;
            nib_q   <= 4'hF;
            en_q    <= '1;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            shad_q  <= shad_d;
            pend_q  <= pend_d;
            nib_q   <= nib_d;
            en_q    <= en_d;
            fd_q    <= fd_d;
        end
    end

    assign bus.A          = nib_q[3];
    assign bus.B          = nib_q[2];
    assign bus.C          = nib_q[1];
    assign bus.D          = nib_q[0];
    assign bus.dig_en     = en_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_ssd_scan_mux.sv
// Directed bench for ssd_scan_mux: 4 digits, DWELL=4, BLANK=2 (24-cycle frame).
// Each frame is checked cycle by cycle against hand-derived slot timing.
module tb_ssd_scan_mux;
    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LIT_ZERO = 4'b0001;
    localparam logic [3:0] LIT_0042 = 4'b0011;
`else
    localparam logic [3:0] LIT_ZERO = 4'b1111;
    localparam logic [3:0] LIT_0042 = 4'b1111;
`endif
    localparam logic [3:0] LIT_ALL = 4'b1111;

    ssd_scan_mux_if #(.NUM_DIGITS(4)) bus ();

    ssd_scan_mux #(
        .NUM_DIGITS(4),
        .DWELL     (4),
        .BLANK     (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset();
        chk("rst_en", 32'(bus.dig_en), 32'hF);
        chk("rst_nib", 32'({bus.A, bus.B, bus.C, bus.D}), 32'hF);
        chk("rst_fd", 32'(bus.frame_done), 32'h0);
    endtask

    // One frame, positions 0..23 sampled on negedges. Optional loads at
    // positions lp0/lp1 and an optional reset at position rp (-1 = none).
    task automatic run_frame(input logic [15:0] exp, input logic [3:0] lit,
                             input int lp0, input logic [15:0] lv0,
                             input int lp1, input logic [15:0] lv1,
                             input int rp);
        int         slot;
        int         ph;
        logic [3:0] en_exp;
        for (int p = 0; p < 24; p++) begin
            @(negedge clk);
            bus.load = 1'b0;
            slot = p / 6;
            ph   = p % 6;
            if (ph < 2 || !lit[slot]) en_exp = 4'hF;
            else                      en_exp = ~(4'b0001 << slot);
            chk("dig_en", 32'(bus.dig_en), 32'(en_exp));
            chk("nibble", 32'({bus.A, bus.B, bus.C, bus.D}),
                32'(exp[slot*4 +: 4]));
            chk("frame_done", 32'(bus.frame_done), 32'(p == 23));
            chk("one_low", 32'($countones(~bus.dig_en) <= 1), 32'h1);
            if (p == lp0) begin
                bus.load   = 1'b1;
                bus.bcd_in = lv0;
            end
            if (p == lp1) begin
                bus.load   = 1'b1;
                bus.bcd_in = lv1;
            end
            if (p == rp) begin
                bus.load = 1'b0;
                rst      = 1'b1;
                @(negedge clk);
                chk_reset();
                rst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.load   = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset();
        rst = 1'b0;

        run_frame(16'h0000, LIT_ZERO, -1, 16'h0, -1, 16'h0, -1);
        run_frame(16'h0000, LIT_ZERO, 10, 16'h1234, -1, 16'h0, -1);
        run_frame(16'h1234, LIT_ALL, 3, 16'h1111, 15, 16'h9876, -1);
        run_frame(16'h9876, LIT_ALL, 22, 16'hABCD, -1, 16'h0, -1);
        run_frame(16'hABCD, LIT_ALL, 5, 16'h0042, -1, 16'h0, -1);
        run_frame(16'h0042, LIT_0042, 5, 16'h5555, -1, 16'h0, 15);
        run_frame(16'h0000, LIT_ZERO, -1, 16'h0, -1, 16'h0, -1);
        run_frame(16'h0000, LIT_ZERO, -1, 16'h0, -1, 16'h0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
